ccr_controller: RTL and testbench

CCR_CONTROLLER -- requirements
Module: ccr_controller

---
 rtl/ccr_controller.sv | 94 +++++++++
 tb/tb_ccr_controller.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ccr_controller.sv
// Condition-code register with per-bit masked update, conditional-jump decision
// with consume-on-test clear, and a small LIFO of shadow CCRs for interrupt nesting.
module ccr_controller #(
    parameter int STACK_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] aluFlags,
    input  logic [2:0] flagWriteMask,
    input  logic       stall,
    input  logic       jumpValid,
    input  logic [1:0] jumpType,
    input  logic       intSave,
    input  logic       rtiRestore,
    output logic [2:0] ccr,
    output logic       jumpTaken,
    output logic [2:0] depth,
    output logic       stackErr
);

    logic [2:0] ccr_q, ccr_d;
    logic [2:0] depth_q, depth_d;
    logic       err_q, err_d;
    logic [2:0] stack_q [STACK_DEPTH];
    logic [2:0] stack_d [STACK_DEPTH];

    logic [2:0] merged, post, top;
    logic       sel;

    always_comb begin
        sel = 1'b1;
        if (jumpType != 2'b11) sel = ccr_q[jumpType];
    end

    assign jumpTaken = jumpValid & ~stall & sel;

    // The jump clear is applied after the merge so it overrides a same-cycle update.
    always_comb begin
        merged = (aluFlags & flagWriteMask) | (ccr_q & ~flagWriteMask);
        post   = merged;
        if (jumpTaken && jumpType != 2'b11) post[jumpType] = 1'b0;
    end

    always_comb begin
        top = 3'b000;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (depth_q == 3'(i + 1)) top = stack_q[i];
    end

    always_comb begin
        ccr_d   = ccr_q;
        depth_d = depth_q;
        err_d   = err_q;
        stack_d = stack_q;
        if (!stall) begin
            ccr_d = post;
            if (intSave) begin
                if (depth_q < 3'(STACK_DEPTH)) begin
                    for (int i = 0; i < STACK_DEPTH; i++)
                        if (depth_q == 3'(i)) stack_d[i] = post;
                    depth_d = depth_q + 3'd1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (rtiRestore) begin
                if (depth_q != 3'd0) begin
                    ccr_d   = top;
                    depth_d = depth_q - 3'd1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccr_q   <= 3'b000;
            depth_q <= 3'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= 3'b000;
        end else begin
            ccr_q   <= ccr_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

    assign ccr      = ccr_q;
    assign depth    = depth_q;
    assign stackErr = err_q;

endmodule

// File: tb/tb_ccr_controller.sv
// Directed plus randomized checks of ccr_controller against a queue-based reference model.
module tb_ccr_controller;

    localparam int SD = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] aluFlags, flagWriteMask;
    logic       stall, jumpValid, intSave, rtiRestore;
    logic [1:0] jumpType;
    logic [2:0] ccr, depth;
    logic       jumpTaken, stackErr;

    int checks = 0;
    int errors = 0;

    logic [2:0] m_ccr;
    logic [2:0] m_q[$];
    logic       m_err;

    ccr_controller #(.STACK_DEPTH(SD)) dut (
        .clk(clk), .rst_n(rst_n), .aluFlags(aluFlags), .flagWriteMask(flagWriteMask),
        .stall(stall), .jumpValid(jumpValid), .jumpType(jumpType), .intSave(intSave),
        .rtiRestore(rtiRestore), .ccr(ccr), .jumpTaken(jumpTaken), .depth(depth),
        .stackErr(stackErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_jump(input logic jv, input logic st, input logic [1:0] jt);
        if (!jv || st) return 1'b0;
        if (jt == 2'b11) return 1'b1;
        return m_ccr[jt];
    endfunction

    // Drive at negedge, check the jump decision, clock once, then check state.
    task automatic step(input logic [2:0] alu, input logic [2:0] mask, input logic st,
                        input logic jv, input logic [1:0] jt, input logic is, input logic rr);
        logic       exp_j;
        logic [2:0] post;
        aluFlags = alu; flagWriteMask = mask; stall = st;
        jumpValid = jv; jumpType = jt; intSave = is; rtiRestore = rr;
        #1;
        exp_j = model_jump(jv, st, jt);
        chk("jumpTaken", 8'(jumpTaken), 8'(exp_j));
        @(posedge clk);
        if (!st) begin
            for (int b = 0; b < 3; b++) post[b] = mask[b] ? alu[b] : m_ccr[b];
            if (exp_j && jt != 2'b11) post[jt] = 1'b0;
            if (is) begin
                if (m_q.size() < SD) m_q.push_back(post);
                else m_err = 1'b1;
                m_ccr = post;
            end else if (rr) begin
                if (m_q.size() > 0) m_ccr = m_q.pop_back();
                else begin m_err = 1'b1; m_ccr = post; end
            end else begin
                m_ccr = post;
            end
        end
        @(negedge clk);
        chk("ccr", 8'(ccr), 8'(m_ccr));
        chk("depth", 8'(depth), 8'(m_q.size()));
        chk("stackErr", 8'(stackErr), 8'(m_err));
    endtask

    task automatic model_reset();
        m_ccr = 3'b000; m_q.delete(); m_err = 1'b0;
    endtask

    initial begin
        aluFlags = 0; flagWriteMask = 0; stall = 0; jumpValid = 0; jumpType = 0;
        intSave = 0; rtiRestore = 0; rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_ccr", 8'(ccr), 8'h0);
        chk("rst_depth", 8'(depth), 8'h0);
        chk("rst_err", 8'(stackErr), 8'h0);
        jumpValid = 1; jumpType = 2'b11; #1;
        chk("rst_jump_uncond", 8'(jumpTaken), 8'h1);
        jumpType = 2'b00; #1;
        chk("rst_jump_jz", 8'(jumpTaken), 8'h0);
        jumpValid = 0;
        @(negedge clk); rst_n = 1'b1;

        // masked update then hold
        step(3'b111, 3'b101, 0, 0, 2'b00, 0, 0);
        chk("mask_101", 8'(ccr), 8'h5);
        step(3'b000, 3'b000, 0, 0, 2'b00, 0, 0);
        chk("mask_hold", 8'(ccr), 8'h5);

        // jump clear
        step(3'b001, 3'b111, 0, 0, 2'b00, 0, 0);
        step(3'b000, 3'b000, 0, 1, 2'b01, 0, 0);
        step(3'b000, 3'b000, 0, 1, 2'b00, 0, 0);
        chk("jz_clear", 8'(ccr), 8'h0);

        // update and clear in the same cycle
        step(3'b001, 3'b001, 0, 1, 2'b00, 0, 0);
        chk("upd_no_jump", 8'(ccr), 8'h1);
        step(3'b001, 3'b001, 0, 1, 2'b00, 0, 0);
        chk("upd_clear_wins", 8'(ccr), 8'h0);

        // nesting, overflow, underflow
        step(3'b100, 3'b111, 0, 0, 2'b00, 1, 0);
        step(3'b010, 3'b111, 0, 0, 2'b00, 1, 0);
        chk("nest_depth2", 8'(depth), 8'h2);
        step(3'b001, 3'b111, 0, 0, 2'b00, 1, 0);
        chk("overflow_err", 8'(stackErr), 8'h1);
        step(3'b111, 3'b111, 0, 0, 2'b00, 0, 1);
        chk("pop_010", 8'(ccr), 8'h2);
        step(3'b111, 3'b111, 0, 0, 2'b00, 0, 1);
        chk("pop_100", 8'(ccr), 8'h4);
        step(3'b011, 3'b111, 0, 0, 2'b00, 0, 1);
        chk("underflow_post", 8'(ccr), 8'h3);
        step(3'b000, 3'b000, 0, 0, 2'b00, 1, 1);

        // stall freezes everything
        step(3'b111, 3'b111, 1, 1, 2'b11, 1, 0);
        step(3'b111, 3'b111, 1, 1, 2'b00, 0, 1);

        // async reset mid-cycle with a full stack
        @(negedge clk); rst_n = 1'b0; #1; model_reset(); @(negedge clk); rst_n = 1'b1;
        step(3'b101, 3'b111, 0, 0, 2'b00, 1, 0);
        step(3'b110, 3'b111, 0, 0, 2'b00, 1, 0);
        step(3'b111, 3'b111, 0, 0, 2'b00, 0, 0);
        #2 rst_n = 1'b0; #1;
        model_reset();
        chk("async_ccr", 8'(ccr), 8'h0);
        chk("async_depth", 8'(depth), 8'h0);
        chk("async_err", 8'(stackErr), 8'h0);
        @(negedge clk); rst_n = 1'b1;
        step(3'b010, 3'b000, 0, 0, 2'b00, 0, 1);
        chk("post_rst_underflow", 8'(stackErr), 8'h1);

        // randomized traffic, with an occasional reset to exercise the stack again
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 50) begin
                rst_n = 1'b0; #1; model_reset(); @(negedge clk); rst_n = 1'b1;
            end
            step(3'($urandom), 3'($urandom), ($urandom_range(0, 4) == 0),
                 1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
